x_buffer_ctrl: RTL and testbench



---
 rtl/x_buffer_ctrl.sv | 141 ++++++++++++++
 tb/tb_x_buffer_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_buffer_ctrl.sv
// x_buffer_ctrl: sequencer for the X operand buffer (load a tile, rotate it, step col/row).
// Optional feature: define XBUF_CTRL_STALL_EN to add the mac_stall input.
module x_buffer_ctrl #(
    parameter int NUM_COLS     = 4,
    parameter int NUM_ROWS     = 4,
    parameter int SHIFT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       load_done,
`ifdef XBUF_CTRL_STALL_EN
    input  logic       mac_stall,
`endif
    output logic       load_en,
    output logic       valid_input,
    output logic       X_shift,
    output logic [2:0] col_counter,
    output logic [3:0] row_counter,
    output logic       mac_en,
    output logic       busy,
    output logic       done
);

    // Counter widths are fixed by the port list; reject parameters that overflow them.
    if (NUM_COLS < 1 || NUM_COLS > 8) begin : g_bad_cols
        $error("x_buffer_ctrl: NUM_COLS must be 1..8");
    end
    if (NUM_ROWS < 1 || NUM_ROWS > 16) begin : g_bad_rows
        $error("x_buffer_ctrl: NUM_ROWS must be 1..16");
    end
    if (SHIFT_CYCLES < 2 || SHIFT_CYCLES > 255) begin : g_bad_shift
        $error("x_buffer_ctrl: SHIFT_CYCLES must be 2..255");
    end

    localparam logic [2:0] COL_LAST   = 3'(NUM_COLS - 1);
    localparam logic [3:0] ROW_LAST   = 4'(NUM_ROWS - 1);
    localparam logic [7:0] SHIFT_LAST = 8'(SHIFT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        NEXT,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] shift_cnt;
    logic       shift_q;
    logic       stall;

`ifdef XBUF_CTRL_STALL_EN
    assign stall = mac_stall;
`else
    assign stall = 1'b0;
`endif

    // Main sequencer: state, tile counters and registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_cnt   <= '0;
            col_counter <= '0;
            row_counter <= '0;
            load_en     <= 1'b0;
            shift_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            load_en <= 1'b0;
            shift_q <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        col_counter <= '0;
                        row_counter <= '0;
                        load_en     <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_done) begin
                        state     <= SHIFT;
                        shift_cnt <= '0;
                        shift_q   <= 1'b1;
                    end else begin
                        load_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_q <= 1'b1;
                    if (!stall) begin
                        if (shift_cnt == SHIFT_LAST) begin
                            state   <= NEXT;
                            shift_q <= 1'b0;
                        end else begin
                            shift_cnt <= shift_cnt + 8'd1;
                        end
                    end
                end
                NEXT: begin
                    if (col_counter != COL_LAST) begin
                        col_counter <= col_counter + 3'd1;
                        state       <= LOAD;
                        load_en     <= 1'b1;
                    end else if (row_counter != ROW_LAST) begin
                        col_counter <= '0;
                        row_counter <= row_counter + 4'd1;
                        state       <= LOAD;
                        load_en     <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A stalled MAC array freezes rotation in the same cycle.
    assign X_shift = shift_q & ~stall;
    assign mac_en  = shift_q & ~stall;

    // Stop accepting words as soon as the buffer reports the tile complete.
    assign in_ready    = load_en & ~load_done;
    assign valid_input = in_valid & in_ready;

endmodule

// File: tb/tb_x_buffer_ctrl.sv
// tb_x_buffer_ctrl: scoreboard bench for x_buffer_ctrl.
// DUT a: 4 cols x 1 row; DUT b: 2 cols x 3 rows; both 8 shift cycles.
module tb_x_buffer_ctrl;

    logic clk = 1'b0;
    logic rst, start, in_valid, sel, stall, ld_auto, ld_man;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [6:0] q[$];

    always #5 clk = ~clk;

    logic a_ir, a_le, a_vi, a_xs, a_me, a_bz, a_dn, a_ld;
    logic b_ir, b_le, b_vi, b_xs, b_me, b_bz, b_dn, b_ld;
    logic [2:0] a_col, b_col;
    logic [3:0] a_row, b_row;
    int a_cnt, b_cnt;

    x_buffer_ctrl #(.NUM_COLS(4), .NUM_ROWS(1), .SHIFT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .in_valid(in_valid),
        .in_ready(a_ir), .load_done(a_ld),
`ifdef XBUF_CTRL_STALL_EN
        .mac_stall(stall),
`endif
        .load_en(a_le), .valid_input(a_vi), .X_shift(a_xs),
        .col_counter(a_col), .row_counter(a_row), .mac_en(a_me),
        .busy(a_bz), .done(a_dn)
    );

    x_buffer_ctrl #(.NUM_COLS(2), .NUM_ROWS(3), .SHIFT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .in_valid(in_valid),
        .in_ready(b_ir), .load_done(b_ld),
`ifdef XBUF_CTRL_STALL_EN
        .mac_stall(1'b0),
`endif
        .load_en(b_le), .valid_input(b_vi), .X_shift(b_xs),
        .col_counter(b_col), .row_counter(b_row), .mac_en(b_me),
        .busy(b_bz), .done(b_dn)
    );

    // Buffer models: tile complete after 3 accepted words.
    always @(posedge clk) begin
        a_cnt <= !a_le ? 0 : a_cnt + (a_vi ? 1 : 0);
        b_cnt <= !b_le ? 0 : b_cnt + (b_vi ? 1 : 0);
    end
    assign a_ld = ld_auto ? (a_cnt == 3) : ld_man;
    assign b_ld = ld_auto ? (b_cnt == 3) : ld_man;

    logic ir, le, vi, xs, me, bz, dn;
    logic [2:0] col;
    logic [3:0] row;
    assign ir  = sel ? b_ir  : a_ir;
    assign le  = sel ? b_le  : a_le;
    assign vi  = sel ? b_vi  : a_vi;
    assign xs  = sel ? b_xs  : a_xs;
    assign me  = sel ? b_me  : a_me;
    assign bz  = sel ? b_bz  : a_bz;
    assign dn  = sel ? b_dn  : a_dn;
    assign col = sel ? b_col : a_col;
    assign row = sel ? b_row : a_row;

    wire [13:0] outs = {ir, le, vi, xs, me, bz, dn, col, row};

    task automatic test_reset();
        sel = 0; in_valid = 1; start = 0; rst = 1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs !== 14'd0) begin
            n_bad++; $display("FAIL reset_hold got=%h exp=0", outs);
        end
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== 14'd0) begin
                n_bad++; $display("FAIL idle_outs cyc=%0d got=%h exp=0", i, outs);
            end
        end
    endtask

    task automatic run_job(input string tag, input int nc, input int nr, input bit poke);
        int xs_tot = 0, ph = 0, vi_tot = 0, bcyc = 0, glitch = 0;
        bit prev = 0, fin = 0;
        logic [6:0] e;
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                q.push_back({4'(r), 3'(c)});
        in_valid = 1; ld_auto = 1;
        start = 1; @(negedge clk); start = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (bz) bcyc++;
            if (vi) vi_tot++;
            if (le && xs) glitch++;
            if (xs) begin xs_tot++; ph++; end
            if (xs && !prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL %s extra_tile row=%0d col=%0d", tag, row, col);
                end else begin
                    e = q.pop_front();
                    if ({row, col} !== e) begin
                        n_bad++;
                        $display("FAIL %s tile got=(%0d,%0d) exp=(%0d,%0d)",
                                 tag, row, col, e[6:3], e[2:0]);
                    end
                end
            end
            if (!xs && prev) begin
                n_cmp++;
                if (ph !== 8) begin
                    n_bad++; $display("FAIL %s phase_shifts got=%0d exp=8", tag, ph);
                end
                ph = 0;
            end
            if (dn) fin = 1;
            prev = xs;
            start = (poke && bz && !fin && cyc % 7 == 3);
            @(negedge clk);
        end
        start = 0;
        n_cmp++;
        if (!fin) begin
            n_bad++; $display("FAIL %s done_timeout got=0 exp=1", tag);
        end
        n_cmp++;
        if ({bz, dn} !== 2'b00) begin
            n_bad++; $display("FAIL %s after_done busy,done got=%b exp=00", tag, {bz, dn});
        end
        n_cmp++;
        if (xs_tot !== 8 * nc * nr) begin
            n_bad++; $display("FAIL %s xs_total got=%0d exp=%0d", tag, xs_tot, 8 * nc * nr);
        end
        n_cmp++;
        if (vi_tot !== 3 * nc * nr) begin
            n_bad++; $display("FAIL %s words got=%0d exp=%0d", tag, vi_tot, 3 * nc * nr);
        end
        n_cmp++;
        if (bcyc !== 13 * nc * nr + 1) begin
            n_bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, bcyc, 13 * nc * nr + 1);
        end
        n_cmp++;
        if (glitch !== 0 || q.size() != 0) begin
            n_bad++; $display("FAIL %s glitch/left got=%0d/%0d exp=0/0", tag, glitch, q.size());
        end
        n_cmp++;
        if ({row, col} !== {4'(nr - 1), 3'(nc - 1)}) begin
            n_bad++; $display("FAIL %s final_ctr got=(%0d,%0d) exp=(%0d,%0d)",
                              tag, row, col, nr - 1, nc - 1);
        end
        q.delete();
    endtask

    task automatic test_single_job();
        sel = 0;
        run_job("single", 4, 1, 0);
    endtask

    task automatic test_row_wrap();
        sel = 1;
        run_job("rowwrap", 2, 3, 1);
        sel = 0;
    endtask

    task automatic test_backpressure();
        logic [4:0] pat = 5'b11001;
        sel = 0; ld_auto = 0; ld_man = 0; in_valid = 0;
        start = 1; @(negedge clk); start = 0;
        for (int i = 4; i >= 0; i--) begin
            in_valid = pat[i];
            #1;
            n_cmp++;
            if ({le, ir, vi, xs} !== {1'b1, 1'b1, pat[i], 1'b0}) begin
                n_bad++;
                $display("FAIL bp_load le,ir,vi,xs got=%b exp=11%b0", {le, ir, vi, xs}, pat[i]);
            end
            @(negedge clk);
        end
        ld_man = 1; in_valid = 1;
        #1;
        n_cmp++;
        if ({le, ir, vi} !== 3'b100) begin
            n_bad++; $display("FAIL bp_ld_same le,ir,vi got=%b exp=100", {le, ir, vi});
        end
        @(negedge clk);
        n_cmp++;
        if ({le, xs, me} !== 3'b011) begin
            n_bad++; $display("FAIL bp_to_shift le,xs,me got=%b exp=011", {le, xs, me});
        end
        rst = 1; @(negedge clk); rst = 0;
    endtask

    task automatic test_stale_load_done();
        sel = 0; ld_auto = 0; ld_man = 1; in_valid = 1;
        start = 1; @(negedge clk); start = 0;
        n_cmp++;
        if ({le, ir, vi} !== 3'b100) begin
            n_bad++; $display("FAIL stale_load le,ir,vi got=%b exp=100", {le, ir, vi});
        end
        @(negedge clk);
        n_cmp++;
        if ({le, xs} !== 2'b01) begin
            n_bad++; $display("FAIL stale_shift le,xs got=%b exp=01", {le, xs});
        end
        rst = 1; @(negedge clk); rst = 0;
        ld_man = 0; ld_auto = 1;
    endtask

    task automatic test_reset_mid_shift();
        bit hit = 0;
        sel = 0; ld_auto = 1; in_valid = 1;
        start = 1; @(negedge clk); start = 0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            if (xs && col == 3'd2) hit = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++; $display("FAIL midrst_reach got=0 exp=1");
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({xs, col} !== {1'b1, 3'd2}) begin
            n_bad++; $display("FAIL midrst_pre xs,col got=%b,%0d exp=1,2", xs, col);
        end
        rst = 1;
        #1;
        n_cmp++;
        if (outs !== 14'd0) begin
            n_bad++; $display("FAIL midrst_async got=%h exp=0", outs);
        end
        @(negedge clk); rst = 0;
        @(negedge clk);
        n_cmp++;
        if (outs !== 14'd0) begin
            n_bad++; $display("FAIL midrst_idle got=%h exp=0", outs);
        end
    endtask

`ifdef XBUF_CTRL_STALL_EN
    task automatic test_stall();
        int n = 0, len = 0;
        bit hit = 0, endp = 0;
        sel = 0; ld_auto = 1; in_valid = 1; stall = 0;
        start = 1; @(negedge clk); start = 0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (xs) hit = 1;
            else @(negedge clk);
        end
        for (int cyc = 0; cyc < 40 && hit && !endp; cyc++) begin
            stall = (cyc >= 2 && cyc < 7);
            #1;
            if (stall) begin
                n_cmp++;
                if ({xs, me} !== 2'b00) begin
                    n_bad++; $display("FAIL stall_gate xs,me got=%b exp=00", {xs, me});
                end
                len++;
            end else if (xs) begin
                n++; len++;
            end else begin
                endp = 1;
            end
            if (!endp) @(negedge clk);
        end
        stall = 0;
        n_cmp++;
        if (n !== 8 || len !== 13) begin
            n_bad++; $display("FAIL stall_phase shifts,len got=%0d,%0d exp=8,13", n, len);
        end
        rst = 1; @(negedge clk); rst = 0;
    endtask
`endif

    initial begin
        rst = 1; start = 0; in_valid = 0; sel = 0; stall = 0;
        ld_auto = 1; ld_man = 0;
        test_reset();
        test_single_job();
        test_backpressure();
        test_stale_load_done();
        test_row_wrap();
        test_reset_mid_shift();
`ifdef XBUF_CTRL_STALL_EN
        test_stall();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
